// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
// Captures the core's two-wide retirement bundles every cycle, queues them in
// program order (slot 0 before slot 1) and replays them one at a time on a
// show-ahead valid/ready stream. The retire side is never stalled: entries
// that do not fit are dropped, counted in the sequence number and flagged.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   update_i             per-slot retire valid
//   pc_i .. mem_wrt_i    per-slot retire fields, slot s at bits [s*W +: W]
//   trace_valid_o/ready  head-of-queue handshake
//   trace_*_o            head entry fields and its retire sequence number
//   count_o              occupied entries
//   overflow_o           sticky: an entry was dropped
//   order_err_o          sticky: slot 1 retired without slot 0
//   clear_i              synchronous clear of both sticky flags
module retire_trace_buffer #(
    parameter int IssueWidth = 2,
    parameter int Depth      = 16,
    parameter int XLEN       = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [IssueWidth-1:0]        update_i,
    input  logic [IssueWidth*XLEN-1:0]   pc_i,
    input  logic [IssueWidth*XLEN-1:0]   instr_i,
    input  logic [IssueWidth*5-1:0]      reg_addr_i,
    input  logic [IssueWidth*XLEN-1:0]   reg_data_i,
    input  logic [IssueWidth*XLEN-1:0]   mem_addr_i,
    input  logic [IssueWidth*XLEN-1:0]   mem_data_i,
    input  logic [IssueWidth-1:0]        mem_wrt_i,
    output logic                         trace_valid_o,
    input  logic                         trace_ready_i,
    output logic [XLEN-1:0]              trace_pc_o,
    output logic [XLEN-1:0]              trace_instr_o,
    output logic [4:0]                   trace_reg_addr_o,
    output logic [XLEN-1:0]              trace_reg_data_o,
    output logic [XLEN-1:0]              trace_mem_addr_o,
    output logic [XLEN-1:0]              trace_mem_data_o,
    output logic                         trace_mem_wrt_o,
    output logic [31:0]                  trace_seq_o,
    output logic [$clog2(Depth):0]       count_o,
    output logic                         overflow_o,
    output logic                         order_err_o,
    input  logic                         clear_i
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam int EW = 32 + 5 * XLEN + 5 + 1;

    logic [EW-1:0] fifo_q [Depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
    logic [CW-1:0] count_q, count_d, free_space;
    logic [31:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d, order_err_q, order_err_d;
    logic [EW-1:0] last_q, last_d, head, out_entry;

    logic          pop;
    logic [1:0]    n_in, accepted;
    logic          we0, we1;
    logic [EW-33:0] body0, body1;
    logic [EW-1:0] wdata0, wdata1;

    always_comb begin
        body0 = {pc_i[XLEN-1:0], instr_i[XLEN-1:0], reg_addr_i[4:0],
                 reg_data_i[XLEN-1:0], mem_addr_i[XLEN-1:0],
                 mem_data_i[XLEN-1:0], mem_wrt_i[0]};
        body1 = {pc_i[2*XLEN-1:XLEN], instr_i[2*XLEN-1:XLEN], reg_addr_i[9:5],
                 reg_data_i[2*XLEN-1:XLEN], mem_addr_i[2*XLEN-1:XLEN],
                 mem_data_i[2*XLEN-1:XLEN], mem_wrt_i[1]};

        pop        = (count_q != '0) && trace_ready_i;
        // A pop this cycle releases its slot for an incoming push.
        free_space = CW'(Depth) - count_q + CW'(pop);
        n_in       = {1'b0, update_i[0]} + {1'b0, update_i[1]};

        // free_space < n_in <= 2 here, so it fits in two bits.
        if (CW'(n_in) <= free_space) accepted = n_in;
        else                         accepted = free_space[1:0];

        // The first valid slot takes the current sequence number; a lone
        // slot 1 is treated as a single push.
        wdata0 = {seq_q, update_i[0] ? body0 : body1};
        wdata1 = {seq_q + 32'd1, body1};
        we0    = accepted != 2'd0;
        we1    = accepted == 2'd2;

        wr_ptr_nxt = wr_ptr_q + AW'(1);
        wr_ptr_d   = wr_ptr_q + AW'(accepted);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(accepted) - CW'(pop);
        seq_d      = seq_q + 32'(n_in);

        // Set beats clear when both happen in the same cycle.
        overflow_d  = (overflow_q & ~clear_i) | (CW'(n_in) > free_space);
        order_err_d = (order_err_q & ~clear_i) | (update_i == 2'b10);

        // Fields keep showing the last head once the queue drains.
        head      = fifo_q[rd_ptr_q];
        out_entry = (count_q != '0) ? head : last_q;
        last_d    = out_entry;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            last_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
            last_q      <= last_d;
        end
    end

    // Storage array carries no reset; unread slots are never presented.
    always_ff @(posedge clk_i) begin
        if (we0) fifo_q[wr_ptr_q]   <= wdata0;
        if (we1) fifo_q[wr_ptr_nxt] <= wdata1;
    end

    assign trace_valid_o = count_q != '0;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign order_err_o   = order_err_q;
    assign {trace_seq_o, trace_pc_o, trace_instr_o, trace_reg_addr_o,
            trace_reg_data_o, trace_mem_addr_o, trace_mem_data_o,
            trace_mem_wrt_o} = out_entry;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [1:0]  update_i = '0;
    logic [63:0] pc_i = '0, instr_i = '0, reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
    logic [9:0]  reg_addr_i = '0;
    logic [1:0]  mem_wrt_i = '0;
    logic        trace_ready_i = 1'b0, clear_i = 1'b0;

    logic        trace_valid_o, trace_mem_wrt_o, overflow_o, order_err_o;
    logic [31:0] trace_pc_o, trace_instr_o, trace_reg_data_o, trace_mem_addr_o, trace_mem_data_o, trace_seq_o;
    logic [4:0]  trace_reg_addr_o;
    logic [4:0]  count_o;

    retire_trace_buffer #(.IssueWidth(2), .Depth(DEPTH), .XLEN(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .update_i(update_i),
        .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
        .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_wrt_i(mem_wrt_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_reg_addr_o(trace_reg_addr_o), .trace_reg_data_o(trace_reg_data_o),
        .trace_mem_addr_o(trace_mem_addr_o), .trace_mem_data_o(trace_mem_data_o),
        .trace_mem_wrt_o(trace_mem_wrt_o), .trace_seq_o(trace_seq_o),
        .count_o(count_o), .overflow_o(overflow_o), .order_err_o(order_err_o),
        .clear_i(clear_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [165:0] body;
        logic [31:0]  seq;
    } exp_t;

    exp_t        exp_q[$];
    int          m_cnt = 0;
    logic [31:0] m_seq = '0;
    logic        m_ovf = 1'b0, m_oerr = 1'b0;
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [165:0] slot_body(input int s);
        return {pc_i[s*32 +: 32], instr_i[s*32 +: 32], reg_addr_i[s*5 +: 5],
                reg_data_i[s*32 +: 32], mem_addr_i[s*32 +: 32],
                mem_data_i[s*32 +: 32], mem_wrt_i[s]};
    endfunction

    // Reference model: FIFO occupancy plus an ordered list of accepted entries.
    task automatic model_step();
        int   n, free, k;
        bit   pop;
        exp_t e;
        n    = int'(update_i[0]) + int'(update_i[1]);
        pop  = (m_cnt > 0) && trace_ready_i;
        free = DEPTH - m_cnt + int'(pop);
        k    = 0;
        for (int s = 0; s < 2; s++) begin
            if (update_i[s]) begin
                if (k < free) begin
                    e.body = slot_body(s);
                    e.seq  = m_seq + 32'(k);
                    exp_q.push_back(e);
                end
                k++;
            end
        end
        m_cnt  = m_cnt - int'(pop) + ((n < free) ? n : free);
        m_ovf  = (m_ovf && !clear_i) || (n > free);
        m_oerr = (m_oerr && !clear_i) || (update_i == 2'b10);
        m_seq  = m_seq + 32'(n);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0; m_seq = '0; m_ovf = 1'b0; m_oerr = 1'b0;
    endtask

    task automatic tick(input logic [1:0] u, input logic r, input logic c,
                        input logic [31:0] p0, input logic [31:0] p1);
        update_i      = u;
        trace_ready_i = r;
        clear_i       = c;
        pc_i          = {p1, p0};
        instr_i       = {$urandom, $urandom};
        reg_data_i    = {$urandom, $urandom};
        mem_addr_i    = {$urandom, $urandom};
        mem_data_i    = {$urandom, $urandom};
        reg_addr_i    = 10'($urandom);
        mem_wrt_i     = 2'($urandom);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        update_i = '0; trace_ready_i = 1'b0; clear_i = 1'b0;
        rstn_i = 1'b0;
        model_clear();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (m_cnt > 0 && i < budget) begin
            tick(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
            i++;
        end
        check("drain_done", 192'(m_cnt), 192'(0));
    endtask

    // Monitor: compares the head against the scoreboard on every handshake.
    always @(negedge clk_i) begin
        exp_t e;
        if (rstn_i) begin
            check("valid", 192'(trace_valid_o), 192'(m_cnt != 0));
            check("count", 192'(count_o), 192'(m_cnt));
            check("overflow", 192'(overflow_o), 192'(m_ovf));
            check("order_err", 192'(order_err_o), 192'(m_oerr));
            if (trace_valid_o && trace_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 192'(1), 192'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("entry", 192'({trace_pc_o, trace_instr_o, trace_reg_addr_o,
                                         trace_reg_data_o, trace_mem_addr_o,
                                         trace_mem_data_o, trace_mem_wrt_o}), 192'(e.body));
                    check("seq", 192'(trace_seq_o), 192'(e.seq));
                end
            end
        end
    end

    initial begin
        do_reset();

        // single-slot stream
        tick(2'b01, 1'b1, 1'b0, 32'h0, 32'h0);
        check("s_pc0", 192'(trace_pc_o), 192'(32'h0));
        check("s_seq0", 192'(trace_seq_o), 192'(0));
        tick(2'b01, 1'b1, 1'b0, 32'h4, 32'h0);
        check("s_pc1", 192'(trace_pc_o), 192'(32'h4));
        tick(2'b01, 1'b1, 1'b0, 32'h8, 32'h0);
        check("s_pc2", 192'(trace_pc_o), 192'(32'h8));
        check("s_seq2", 192'(trace_seq_o), 192'(2));
        drain(4);

        // dual retire, consumer stalled
        do_reset();
        for (int i = 0; i < 4; i++)
            tick(2'b11, 1'b0, 1'b0, 32'(i * 8), 32'(i * 8 + 4));
        check("dual_count", 192'(count_o), 192'(8));
        check("dual_head_pc", 192'(trace_pc_o), 192'(32'h0));
        drain(10);

        // overflow and sequence gap
        do_reset();
        for (int i = 0; i < 9; i++)
            tick(2'b11, 1'b0, 1'b0, 32'(i * 8), 32'(i * 8 + 4));
        check("ovf_count", 192'(count_o), 192'(16));
        check("ovf_flag", 192'(overflow_o), 192'(1));
        drain(20);
        tick(2'b01, 1'b1, 1'b0, 32'h100, 32'h0);
        check("ovf_next_seq", 192'(trace_seq_o), 192'(18));
        tick(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        check("ovf_cleared", 192'(overflow_o), 192'(0));
        drain(4);

        // full with simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++)
            tick(2'b11, 1'b0, 1'b0, 32'(i * 8), 32'(i * 8 + 4));
        check("full_count", 192'(count_o), 192'(16));
        check("full_no_ovf", 192'(overflow_o), 192'(0));
        tick(2'b11, 1'b1, 1'b0, 32'h200, 32'h204);
        check("fullpop_count", 192'(count_o), 192'(16));
        check("fullpop_ovf", 192'(overflow_o), 192'(1));
        drain(20);

        // order error, clear, set-beats-clear
        do_reset();
        tick(2'b10, 1'b0, 1'b0, 32'h0, 32'h40);
        check("oerr_flag", 192'(order_err_o), 192'(1));
        check("oerr_pc", 192'(trace_pc_o), 192'(32'h40));
        check("oerr_count", 192'(count_o), 192'(1));
        tick(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        check("oerr_clear", 192'(order_err_o), 192'(0));
        tick(2'b10, 1'b0, 1'b1, 32'h0, 32'h44);
        check("oerr_set_wins", 192'(order_err_o), 192'(1));
        drain(4);

        // asynchronous reset with entries queued
        do_reset();
        tick(2'b11, 1'b0, 1'b0, 32'h10, 32'h14);
        tick(2'b11, 1'b0, 1'b0, 32'h18, 32'h1C);
        tick(2'b01, 1'b0, 1'b0, 32'h20, 32'h0);
        check("pre_rst_count", 192'(count_o), 192'(5));
        #2;
        rstn_i = 1'b0;
        model_clear();
        #1;
        check("rst_valid", 192'(trace_valid_o), 192'(0));
        check("rst_count", 192'(count_o), 192'(0));
        check("rst_pc", 192'(trace_pc_o), 192'(0));
        check("rst_seq", 192'(trace_seq_o), 192'(0));
        do_reset();
        tick(2'b01, 1'b0, 1'b0, 32'h80, 32'h0);
        check("post_rst_seq", 192'(trace_seq_o), 192'(0));
        check("post_rst_pc", 192'(trace_pc_o), 192'(32'h80));
        drain(4);

        // randomized traffic, varying consumer pressure
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (i < 1000)      r = ($urandom_range(0, 3) == 0);
            else if (i < 2000) r = ($urandom_range(0, 3) != 0);
            else               r = 1'(($urandom));
            tick(2'($urandom), r, ($urandom_range(0, 31) == 0), $urandom, $urandom);
        end
        drain(40);
        check("scoreboard_empty", 192'(exp_q.size()), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
